// File: rtl/branch_target_predictor.sv
// Direct-mapped branch target predictor.
// Each entry holds a valid bit, a tag, a target and a saturating counter.
// Lookup is combinational and returns the table contents before any
// same-cycle update. Resolved branches train the table on the clock edge.
// Branch and mispredict statistics saturate and are not cleared by a flush.
module branch_target_predictor #(
    parameter int ENTRIES  = 16,
    parameter int CNT_BITS = 2,
    parameter int MODE     = 1
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic [31:0] lookup_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        upd_pred_taken,
    input  logic [31:0] upd_pred_target,
    input  logic        flush_tbl,
    output logic        mispredict,
    output logic [31:0] branch_cnt,
    output logic [31:0] miss_cnt
);

    localparam int IDX   = $clog2(ENTRIES);
    localparam int TAG_W = 30 - IDX;
    localparam bit DYN   = (MODE == 1);

    localparam logic [CNT_BITS-1:0] CNT_MAX = '1;
    localparam logic [CNT_BITS-1:0] CNT_ONE = CNT_BITS'(1);
    // Weakly taken: only the MSB set. Weakly not-taken: one below that.
    localparam logic [CNT_BITS-1:0] CNT_WT  = CNT_BITS'(1 << (CNT_BITS - 1));
    localparam logic [CNT_BITS-1:0] CNT_WNT = CNT_BITS'((1 << (CNT_BITS - 1)) - 1);

    logic                valid_q  [ENTRIES];
    logic [TAG_W-1:0]    tag_q    [ENTRIES];
    logic [31:0]         target_q [ENTRIES];
    logic [CNT_BITS-1:0] cnt_q    [ENTRIES];

    logic [31:0] branch_cnt_q;
    logic [31:0] miss_cnt_q;

    logic [IDX-1:0]   lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic             lk_hit;
    logic [IDX-1:0]   up_idx;
    logic [TAG_W-1:0] up_tag;
    logic             up_hit;

    // The byte offset within a word never participates in indexing or tagging.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{lookup_pc[1:0], upd_pc[1:0]};

    // Combinational lookup and prediction; sees the pre-update table.
    always_comb begin
        lk_idx      = lookup_pc[IDX+1:2];
        lk_tag      = lookup_pc[31:IDX+2];
        lk_hit      = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        pred_taken  = DYN && lk_hit && cnt_q[lk_idx][CNT_BITS-1];
        pred_target = pred_taken ? target_q[lk_idx] : (lookup_pc + 32'd4);
    end

    // Update-side decode and mispredict detection.
    always_comb begin
        up_idx     = upd_pc[IDX+1:2];
        up_tag     = upd_pc[31:IDX+2];
        up_hit     = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
        mispredict = upd_valid &&
                     ((upd_taken != upd_pred_taken) ||
                      (upd_taken && (upd_pred_target != upd_target)));
    end

    // Table training; a flush wins over a simultaneous update.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                cnt_q[i]    <= CNT_WNT;
            end
        end else if (flush_tbl) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
            end
        end else if (upd_valid) begin
            if (up_hit) begin
                if (upd_taken) begin
                    if (cnt_q[up_idx] != CNT_MAX) begin
                        cnt_q[up_idx] <= cnt_q[up_idx] + CNT_ONE;
                    end
                    target_q[up_idx] <= upd_target;
                end else if (cnt_q[up_idx] != '0) begin
                    cnt_q[up_idx] <= cnt_q[up_idx] - CNT_ONE;
                end
            end else if (upd_taken) begin
                valid_q[up_idx]  <= 1'b1;
                tag_q[up_idx]    <= up_tag;
                target_q[up_idx] <= upd_target;
                cnt_q[up_idx]    <= CNT_WT;
            end
        end
    end

    // Saturating resolved-branch and mispredict statistics.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            branch_cnt_q <= '0;
            miss_cnt_q   <= '0;
        end else if (upd_valid) begin
            if (branch_cnt_q != 32'hFFFF_FFFF) begin
                branch_cnt_q <= branch_cnt_q + 32'd1;
            end
            if (mispredict && (miss_cnt_q != 32'hFFFF_FFFF)) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign branch_cnt = branch_cnt_q;
    assign miss_cnt   = miss_cnt_q;

endmodule
